// File: rtl/rom_sdram_writer.sv
// Packs the iosys ROM byte stream into little-endian 16-bit SDRAM writes at BASE_ADDR,
// buffering words in a small FIFO while the SDRAM loader port stalls.
module rom_sdram_writer #(
    parameter logic [22:0] BASE_ADDR  = 23'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        wclk,
    input  logic        resetn,
    input  logic        rom_loading,
    input  logic [7:0]  rom_do,
    input  logic        rom_do_valid,
    input  logic [23:0] rom_mask,
    output logic [22:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_ds,
    output logic        sd_wr,
    input  logic        sd_wait,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [23:0] rom_bytes
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] data;
        logic [1:0]  ds;
    } word_t;

    state_t         state;
    word_t          mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [23:0]    offset;
    logic [7:0]     pair_lo;
    logic           pair_valid;
    logic [22:0]    pair_addr;
    logic           rom_loading_d;

    logic           start;
    logic [23:0]    cur_off;
    logic [23:0]    bytes_base;
    logic           accept;
    logic           in_range;
    logic           odd_push;
    logic           flush_push;
    logic           push;
    logic           push_ok;
    logic           pop;
    logic           full;
    logic           empty;
    logic           drop;
    logic [22:0]    byte_addr;
    word_t          push_word;

    // A start in any state restarts the byte path from offset 0 in the same cycle.
    always_comb begin
        start      = rom_loading & ~rom_loading_d;
        cur_off    = start ? 24'd0 : offset;
        bytes_base = start ? 24'd0 : rom_bytes;
        accept     = rom_loading & rom_do_valid & (start | (state == LOAD));
        in_range   = cur_off <= rom_mask;
        odd_push   = accept & in_range & cur_off[0];
        flush_push = (state == FLUSH) & pair_valid & ~start;
        push       = odd_push | flush_push;
        full       = count == CW'(FIFO_DEPTH);
        empty      = count == '0;
        push_ok    = push & ~full;
        pop        = sd_wr & ~sd_wait & ~start;
        drop       = (accept & ~in_range) | (push & full);
        byte_addr  = BASE_ADDR + {cur_off[22:1], 1'b0};
        if (odd_push) begin
            push_word.addr = byte_addr;
            push_word.data = {rom_do, pair_lo};
            push_word.ds   = 2'b11;
        end else begin
            push_word.addr = pair_addr;
            push_word.data = {8'h00, pair_lo};
            push_word.ds   = 2'b01;
        end
    end

    // NOTE: FIFO storage has no reset; validity is tracked entirely by count and the pointers.
    always_ff @(posedge wclk) begin
        if (push_ok)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge wclk) begin
        if (!resetn) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            rom_bytes     <= '0;
            offset        <= '0;
            pair_lo       <= '0;
            pair_valid    <= 1'b0;
            pair_addr     <= '0;
            rom_loading_d <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            sd_wr         <= 1'b0;
            sd_addr       <= '0;
            sd_din        <= '0;
            sd_ds         <= '0;
        end else begin
            rom_loading_d <= rom_loading;
            done          <= 1'b0;
            offset        <= accept ? cur_off + 24'd1 : cur_off;
            rom_bytes     <= (accept && bytes_base != 24'hFFFFFF) ? bytes_base + 24'd1 : bytes_base;
            overflow      <= (overflow & ~start) | drop;

            if (accept && in_range && !cur_off[0]) begin
                pair_valid <= 1'b1;
                pair_lo    <= rom_do;
                pair_addr  <= byte_addr;
            end else if (push || start) begin
                pair_valid <= 1'b0;
            end

            if (start) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(push_ok);
                rd_ptr <= rd_ptr + PW'(pop);
                count  <= count + CW'(push_ok) - CW'(pop);
            end

            // The head word stays queued until accepted, so it still occupies a FIFO slot.
            if (start || pop) begin
                sd_wr <= 1'b0;
            end else if (!sd_wr && !empty) begin
                sd_wr   <= 1'b1;
                sd_addr <= mem[rd_ptr].addr;
                sd_din  <= mem[rd_ptr].data;
                sd_ds   <= mem[rd_ptr].ds;
            end

            if (start) begin
                state <= LOAD;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD:  if (!rom_loading) state <= FLUSH;
                    FLUSH: state <= DRAIN;
                    DRAIN: if (empty && !sd_wr) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
